// File: rtl/sorted_stream_reader_pkg.sv
// sorted_stream_reader_pkg: shared defaults, FSM encoding and order rule for the sorted stream reader
package sorted_stream_reader_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;
    function automatic logic order_bad(input logic ascending, input logic prev_gt, input logic prev_lt);
        return ascending ? prev_gt : prev_lt;
    endfunction
endpackage

// File: rtl/sorted_stream_reader_if.sv
// sorted_stream_reader_if: valid/ready stream port carrying one sorted word per beat
interface sorted_stream_reader_if
    import sorted_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = $clog2(DEPTH_DEF)
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IDX_W-1:0]  out_idx;
    modport master(output out_data, out_valid, out_last, out_idx, input out_ready);
    modport slave(input out_data, out_valid, out_last, out_idx, output out_ready);
endinterface

// File: rtl/sorted_stream_reader_checker.sv
// sorted_stream_reader_checker: compares each accepted beat against the previous one, sticky error flag
module sorted_stream_reader_checker
    import sorted_stream_reader_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit ASCENDING = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              beat,
    input  logic              first,
    input  logic [DATA_W-1:0] data,
    output logic              err
);
    logic [DATA_W-1:0] prev;
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            prev <= '0;
            err  <= 1'b0;
        end else if (beat) begin
            prev <= data;
            err  <= err | (!first && order_bad(ASCENDING, prev > data, prev < data));
        end
    end
endmodule

// File: rtl/sorted_stream_reader.sv
// sorted_stream_reader: snapshots the sorter's parallel result and streams it out one word per beat
module sorted_stream_reader
    import sorted_stream_reader_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter bit ASCENDING = 1'b1,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DEPTH*DATA_W-1:0] sorted_flat,
    input  logic                    snap_req,
    output logic                    busy,
    output logic                    done,
    output logic                    order_err,
    sorted_stream_reader_if.master  ob
);
    state_t            state, state_nx;
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              accept, beat, last;
    assign accept = (state == S_IDLE) && en && snap_req;
    assign last   = idx == IDX_W'(DEPTH - 1);
    assign beat   = ob.out_valid && ob.out_ready;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= '0;
            for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                for (int i = 0; i < DEPTH; i++) shadow[i] <= sorted_flat[i*DATA_W +: DATA_W];
            // the last beat clears the index so it never wraps by overflow
            if (beat) idx <= last ? '0 : idx + 1'b1;
        end
    end
    always_comb begin
        state_nx     = state;
        ob.out_valid = state == S_STREAM;
        ob.out_data  = ob.out_valid ? shadow[idx] : '0;
        ob.out_last  = ob.out_valid && last;
        ob.out_idx   = idx;
        busy         = state != S_IDLE;
        done         = state == S_DONE;
        if (state == S_IDLE) state_nx = accept ? S_STREAM : S_IDLE;
        else if (state == S_STREAM) state_nx = (beat && last) ? S_DONE : S_STREAM;
        else state_nx = S_IDLE;
    end
    sorted_stream_reader_checker #(
        .DATA_W   (DATA_W),
        .ASCENDING(ASCENDING)
    ) u_checker (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .beat (beat),
        .first(idx == '0),
        .data (ob.out_data),
        .err  (order_err)
    );
endmodule

// File: tb/tb_sorted_stream_reader.sv
// tb_sorted_stream_reader: directed scenarios for the ascending and descending reader variants
module tb_sorted_stream_reader;
    logic         clk = 1'b0;
    logic         rst, en, snap_req, ready;
    logic [511:0] sorted_flat;
    logic         a_busy, a_done, a_err, d_busy, d_done, d_err;
    int           checks = 0, errors = 0;
    logic [31:0]  got [16], gotd [16], w [16];
    int           nb, rise, held_bad, idx_bad, last_bad, done_cyc, last_cyc;
    bit           done_seen;

    sorted_stream_reader_if #(.DATA_W(32), .IDX_W(4)) a_if ();
    sorted_stream_reader_if #(.DATA_W(32), .IDX_W(4)) d_if ();
    assign a_if.out_ready = ready;
    assign d_if.out_ready = ready;

    sorted_stream_reader #(.DATA_W(32), .DEPTH(16), .ASCENDING(1'b1)) dut_asc (
        .clk(clk), .rst(rst), .en(en), .sorted_flat(sorted_flat), .snap_req(snap_req),
        .busy(a_busy), .done(a_done), .order_err(a_err), .ob(a_if)
    );
    sorted_stream_reader #(.DATA_W(32), .DEPTH(16), .ASCENDING(1'b0)) dut_desc (
        .clk(clk), .rst(rst), .en(en), .sorted_flat(sorted_flat), .snap_req(snap_req),
        .busy(d_busy), .done(d_done), .order_err(d_err), .ob(d_if)
    );

    always #5 clk = ~clk;

    task automatic snap();
        for (int i = 0; i < 16; i++) sorted_flat[i*32 +: 32] = w[i];
        en = 1'b1;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    // drives out_ready and records every accepted beat until done (bounded)
    task automatic run_stream(input bit toggle);
        logic [31:0] hd;
        bit hv;
        hd = '0; hv = 1'b0;
        nb = 0; rise = -1; held_bad = 0; idx_bad = 0; last_bad = 0;
        done_cyc = -1; last_cyc = -1; done_seen = 1'b0;
        for (int c = 0; c < 100 && !done_seen; c++) begin
            ready = toggle ? (c % 2 == 0) : 1'b1;
            if (a_err && rise < 0) rise = nb;
            if (a_done) begin
                done_seen = 1'b1;
                done_cyc = c;
            end else if (a_if.out_valid) begin
                if (hv && a_if.out_data !== hd) held_bad++;
                if (a_if.out_idx !== 4'(nb)) idx_bad++;
                if (a_if.out_last !== (nb == 15)) last_bad++;
                if (ready) begin
                    if (nb < 16) begin
                        got[nb] = a_if.out_data;
                        gotd[nb] = d_if.out_data;
                    end
                    nb++;
                    hv = 1'b0;
                    if (nb == 16) last_cyc = c;
                end else begin
                    hv = 1'b1;
                    hd = a_if.out_data;
                end
            end
            if (!done_seen) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; snap_req = 1'b0; ready = 1'b1; sorted_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_if.out_valid, a_if.out_last, a_done, a_err, a_if.out_idx, a_if.out_data} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b last=%b done=%b err=%b idx=%0d data=%h, all expected 0",
                     a_busy, a_if.out_valid, a_if.out_last, a_done, a_err, a_if.out_idx, a_if.out_data);
        end
        rst = 1'b1;
        for (int i = 0; i < 16; i++) w[i] = 32'(i + 1);
        w[1] = 32'd0;
        snap();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (a_err !== 1'b1 || a_if.out_idx !== 4'd5) begin
            errors++;
            $display("FAIL reset_prestream: err=%b idx=%0d expected err=1 idx=5", a_err, a_if.out_idx);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({a_busy, a_if.out_valid, a_if.out_last, a_done, a_err, a_if.out_idx, a_if.out_data} !== '0) begin
                errors++;
                $display("FAIL reset_midstream[%0d]: busy=%b valid=%b done=%b err=%b idx=%0d data=%h, all expected 0",
                         k, a_busy, a_if.out_valid, a_done, a_err, a_if.out_idx, a_if.out_data);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%b busy=%b expected 0 0", a_done, a_busy);
        end
    endtask

    task automatic test_ascending();
        for (int i = 0; i < 16; i++) w[i] = 32'(i + 1);
        snap();
        checks++;
        if (a_if.out_valid !== 1'b1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL asc_first_valid: valid=%b busy=%b expected 1 1", a_if.out_valid, a_busy);
        end
        run_stream(1'b0);
        checks++;
        if (nb != 16 || last_cyc != 15 || done_cyc != 16) begin
            errors++;
            $display("FAIL asc_timing: beats=%0d last_cyc=%0d done_cyc=%0d expected 16 15 16", nb, last_cyc, done_cyc);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== w[i]) begin
                errors++;
                $display("FAIL asc_data[%0d]: got %h expected %h", i, got[i], w[i]);
            end
        end
        checks++;
        if (idx_bad != 0 || last_bad != 0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL asc_idx_last_err: idx_bad=%0d last_bad=%0d err=%b expected 0 0 0", idx_bad, last_bad, a_err);
        end
        @(posedge clk); #1;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL asc_done_pulse: done=%b busy=%b expected 0 0", a_done, a_busy);
        end
    endtask

    task automatic test_ready_toggle();
        for (int i = 0; i < 16; i++) w[i] = 32'(i + 1);
        snap();
        run_stream(1'b1);
        checks++;
        if (nb != 16 || last_cyc != 30 || done_cyc != 31) begin
            errors++;
            $display("FAIL tog_timing: beats=%0d last_cyc=%0d done_cyc=%0d expected 16 30 31", nb, last_cyc, done_cyc);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== w[i]) begin
                errors++;
                $display("FAIL tog_data[%0d]: got %h expected %h", i, got[i], w[i]);
            end
        end
        checks++;
        if (held_bad != 0 || idx_bad != 0 || last_bad != 0) begin
            errors++;
            $display("FAIL tog_hold: held_bad=%0d idx_bad=%0d last_bad=%0d expected 0 0 0", held_bad, idx_bad, last_bad);
        end
        ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_order_err();
        for (int i = 0; i < 16; i++) w[i] = 32'(i + 1);
        w[8] = 32'd3;
        snap();
        run_stream(1'b0);
        checks++;
        if (rise != 9 || a_err !== 1'b1 || nb != 16) begin
            errors++;
            $display("FAIL err_rise: rise_after_beat=%0d err_at_done=%b beats=%0d expected 9 1 16", rise, a_err, nb);
        end
        @(posedge clk); #1;
        checks++;
        if (a_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b expected 1", a_err);
        end
        w[8] = 32'd9;
        snap();
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b expected 0", a_err);
        end
        run_stream(1'b0);
        checks++;
        if (a_err !== 1'b0 || nb != 16) begin
            errors++;
            $display("FAIL err_clean_run: err=%b beats=%0d expected 0 16", a_err, nb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore();
        for (int i = 0; i < 16; i++) w[i] = 32'(i + 1);
        ready = 1'b0;
        snap();
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) sorted_flat[i*32 +: 32] = 32'(100 + i);
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        checks++;
        if (a_if.out_idx !== 4'd0 || a_if.out_data !== 32'd1 || a_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ign_busy_hold: idx=%0d data=%h valid=%b expected 0 1 1", a_if.out_idx, a_if.out_data, a_if.out_valid);
        end
        run_stream(1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== w[i]) begin
                errors++;
                $display("FAIL ign_data[%0d]: got %h expected %h", i, got[i], w[i]);
            end
        end
        @(posedge clk); #1;
        en = 1'b0;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        en = 1'b1;
        checks++;
        if (a_busy !== 1'b0 || a_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ign_en_low: busy=%b valid=%b expected 0 0", a_busy, a_if.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_queue: busy=%b expected 0", a_busy);
        end
    endtask

    task automatic test_equal();
        for (int i = 0; i < 16; i++) w[i] = 32'hFFFF_FFFF;
        snap();
        run_stream(1'b0);
        checks++;
        if (nb != 16 || a_err !== 1'b0 || d_err !== 1'b0) begin
            errors++;
            $display("FAIL eq_run: beats=%0d asc_err=%b desc_err=%b expected 16 0 0", nb, a_err, d_err);
        end
        checks++;
        if (got[15] !== 32'hFFFF_FFFF || gotd[0] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL eq_data: last=%h desc_first=%h expected ffffffff ffffffff", got[15], gotd[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_descending();
        for (int i = 0; i < 16; i++) w[i] = 32'(16 - i);
        snap();
        run_stream(1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (gotd[i] !== w[i]) begin
                errors++;
                $display("FAIL desc_data[%0d]: got %h expected %h", i, gotd[i], w[i]);
            end
        end
        checks++;
        if (d_err !== 1'b0 || d_done !== 1'b1) begin
            errors++;
            $display("FAIL desc_err: err=%b done=%b expected 0 1", d_err, d_done);
        end
        checks++;
        if (a_err !== 1'b1 || rise != 2) begin
            errors++;
            $display("FAIL desc_on_asc: err=%b rise_after_beat=%0d expected 1 2", a_err, rise);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_ready_toggle();
        test_order_err();
        test_ignore();
        test_equal();
        test_descending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
